uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
// - Buffered UART transmitter: accepts bytes on a valid pulse into a small FIFO, serialises each one onto a single line.
// - Frame: start(0), 8 data bits LSB first, optional parity bit, stop(1). Line idles high.
// - Same frame format and parity controls as uart_rx_top, so its out pin can drive that receiver's data input.
// - Adds queuing, back-to-back frames and overflow reporting for bursty producers.
// PARAMETERS
// - CLKS_PER_BIT  1  clk1 cycles each serial bit is held (>=1)
// - DEPTH         4  FIFO entries (power of 2, >=2)
// PORTS
// - clk1         in   1  transmit clock, all logic on rising edge
// - rst          in   1  asynchronous, active-low reset
// - data         in   8  byte to send
// - data_valid   in   1  push strobe, one byte per high cycle
// - parity_en    in   1  1 = insert parity bit after data
// - parity_type  in   1  0 = even, 1 = odd
// - out          out  1  serial line (registered)
// - busy         out  1  high while a frame is on the line
// - fifo_full    out  1  FIFO holds DEPTH entries
// - overflow     out  1  one-cycle pulse: a push was dropped
// BEHAVIOUR
// - Reset (rst=0, async): out=1, busy=0, fifo_full=0, overflow=0; FIFO emptied; FSM -> IDLE; prescaler and bit counter cleared.
// - Reset mid-frame aborts the frame: out returns to 1 immediately.
// - Push: data_valid && !fifo_full writes data at the edge.
// - Push while fifo_full is dropped, even if a pop happens in the same cycle. overflow=1 for the following cycle.
// - Pop happens only on entry to START. fifo_full and count are registered.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE: out=1, busy=0. If FIFO non-empty: pop the byte into shift reg, latch parity_en/parity_type, go to START.
//   START: out=0 for CLKS_PER_BIT cycles, then DATA.
//   DATA: out=shift[0]; shift right every CLKS_PER_BIT cycles; after 8 bits go to PARITY if the latched parity_en is set, else STOP.
//   PARITY: out = ^byte for even, ~^byte for odd; held CLKS_PER_BIT cycles; then STOP.
//   STOP: out=1 for CLKS_PER_BIT cycles. If FIFO non-empty, pop and go straight to START (no idle gap); else go to IDLE.
// - Latency: with IDLE and FIFO empty, data_valid sampled at edge k gives out=0 after edge k+1.
// - Frame length is 10 or 11 bit-times (10*CLKS_PER_BIT or 11*CLKS_PER_BIT cycles).
// - busy=1 from START entry until STOP exits to IDLE.
// - Changes to parity_en/parity_type mid-frame do not affect the current frame.
// - Prescaler counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
// - Bit counter is 3 bits and wraps after bit 7.
// - FIFO pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
// STRUCTURE
// - uart_pkg: FSM state encoding, PARITY_EVEN=0/PARITY_ODD=1, START_BIT=0/STOP_BIT=1, DATA_BITS=8.
//   Shared with the rx path.
// - Sub-module uart_tx_fifo (DEPTH x 8 sync FIFO; push/pop/full/empty, async active-low reset).
// - The top holds the FSM, prescaler, bit counter, shift register and parity logic.
// TESTING
// 1. Assert rst=0 mid-run -> out=1, busy=0, fifo_full=0, overflow=0 immediately. FIFO empty after release.
// 2. CLKS_PER_BIT=4, parity_en=0, push 0xA5 -> out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. Start falls at edge k+1. busy high for 40 cycles.
// 3. parity_en=1, push 0x03 with parity_type=0 -> parity bit 0. Repeat with parity_type=1 -> 1. Frame is 11 bits.
// 4. DEPTH=4, push 6 bytes 0x10..0x15 on consecutive cycles -> 0x10 starts sending and 0x11..0x14 fill the FIFO (fifo_full=1). 0x15 is dropped with a 1-cycle overflow pulse.
//    Expect 5 contiguous frames with no idle between stop and start.
// 5. Toggle parity_type during the DATA state -> the current frame uses the latched type, the next frame uses the new one.
// 6. Loopback: CLKS_PER_BIT matched to the uart_rx_top sampling rate, out -> rx data input.
//    Send 256 random bytes with random parity settings -> p_data matches each byte; parity_err=0, stop_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels, parity selection.
// The receive path imports this package as well.
package uart_pkg;

   localparam int   DATA_BITS   = 8;
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;
   localparam logic START_BIT   = 1'b0;
   localparam logic STOP_BIT    = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   // Even parity makes the total count of ones even; odd parity inverts that bit.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic ptype);
      return (^b) ^ (ptype == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// DEPTH x WIDTH synchronous FIFO for the UART transmitter.
// The head entry is visible combinationally so it can be popped and used on the same edge.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [AW:0]      count_next;
   logic             do_push;
   logic             do_pop;

   // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign empty    = (count_reg == '0);
   assign pop_data = mem[rd_ptr_reg];

   always_comb begin
      count_next = count_reg;
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         full      <= (count_next == (AW+1)'(DEPTH));
         overflow  <= push && full;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed serialiser producing start, 8 data bits LSB first,
// optional parity and stop, with back-to-back frames while the FIFO holds data.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int DEPTH        = 4
) (
   input  logic       clk1,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       data_valid,
   input  logic       parity_en,
   input  logic       parity_type,
   output logic       out,
   output logic       busy,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   uart_state_t          state_reg, state_next;
   logic [PW-1:0]        prescale_reg, prescale_next;
   logic [2:0]           bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_en_reg, par_en_next;
   logic                 par_bit_reg, par_bit_next;
   logic                 out_next;
   logic                 busy_next;
   logic                 load;
   logic                 bit_done;
   logic                 fifo_pop;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_data;

   uart_tx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk1      (clk1),
      .rst       (rst),
      .push      (data_valid),
      .push_data (data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .overflow  (overflow)
   );

   assign bit_done = (prescale_reg == PW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_next    = state_reg;
      prescale_next = bit_done ? '0 : prescale_reg + 1'b1;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      par_en_next   = par_en_reg;
      par_bit_next  = par_bit_reg;
      load          = 1'b0;
      fifo_pop      = 1'b0;
      out_next      = STOP_BIT;
      busy_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            prescale_next = '0;
            if (!fifo_empty) load = 1'b1;
         end
         START: begin
            if (bit_done) state_next = DATA;
         end
         DATA: begin
            if (bit_done) begin
               shift_next   = shift_reg >> 1;
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
                  state_next = par_en_reg ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_done) state_next = STOP;
         end
         STOP: begin
            if (bit_done) begin
               if (!fifo_empty) load = 1'b1;
               else             state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // Frame settings are captured with the byte so mid-frame control changes are ignored.
      if (load) begin
         fifo_pop      = 1'b1;
         shift_next    = fifo_data;
         par_en_next   = parity_en;
         par_bit_next  = parity_bit(fifo_data, parity_type);
         bit_cnt_next  = '0;
         prescale_next = '0;
         state_next    = START;
      end

      // The line is registered from the next state so the start bit appears one edge after the pop.
      case (state_next)
         START:   out_next = START_BIT;
         DATA:    out_next = shift_next[0];
         PARITY:  out_next = par_bit_next;
         default: out_next = STOP_BIT;
      endcase
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         prescale_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         par_en_reg   <= 1'b0;
         par_bit_reg  <= 1'b0;
         out          <= STOP_BIT;
         busy         <= 1'b0;
      end else begin
         state_reg    <= state_next;
         prescale_reg <= prescale_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         par_en_reg   <= par_en_next;
         par_bit_reg  <= par_bit_next;
         out          <= out_next;
         busy         <= busy_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame-level reference model compared every cycle,
// plus hand-computed frames, overflow, back-to-back and reset scenarios.
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk1 = 1'b0;
   logic       rst  = 1'b0;
   logic [7:0] data = '0;
   logic       data_valid  = 1'b0;
   logic       parity_en   = 1'b0;
   logic       parity_type = 1'b0;
   logic       out, busy, fifo_full, overflow;

   int checks = 0;
   int errors = 0;

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk1        (clk1),
      .rst         (rst),
      .data        (data),
      .data_valid  (data_valid),
      .parity_en   (parity_en),
      .parity_type (parity_type),
      .out         (out),
      .busy        (busy),
      .fifo_full   (fifo_full),
      .overflow    (overflow)
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a byte queue plus the list of line levels still to be emitted.
   logic [7:0] mq[$];
   bit         line_q[$];
   logic       exp_out = 1'b1, exp_busy = 1'b0, exp_full = 1'b0, exp_ovf = 1'b0;
   logic [7:0] m_byte;
   bit         m_full_pre;
   bit         m_pbit;

   always @(posedge clk1 or negedge rst) begin
      if (!rst) begin
         mq.delete();
         line_q.delete();
         exp_out  = 1'b1;
         exp_busy = 1'b0;
         exp_full = 1'b0;
         exp_ovf  = 1'b0;
      end else begin
         m_full_pre = (mq.size() == DEPTH);
         if (line_q.size() == 0 && mq.size() > 0) begin
            m_byte = mq.pop_front();
            m_pbit = (($countones(m_byte) % 2) == 1) ^ parity_type;
            for (int c = 0; c < CPB; c++) line_q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
               for (int c = 0; c < CPB; c++) line_q.push_back(m_byte[i]);
            if (parity_en)
               for (int c = 0; c < CPB; c++) line_q.push_back(m_pbit);
            for (int c = 0; c < CPB; c++) line_q.push_back(1'b1);
         end
         if (line_q.size() > 0) begin
            exp_out  = line_q.pop_front();
            exp_busy = 1'b1;
         end else begin
            exp_out  = 1'b1;
            exp_busy = 1'b0;
         end
         exp_ovf = data_valid && m_full_pre;
         if (data_valid && !m_full_pre) mq.push_back(data);
         exp_full = (mq.size() == DEPTH);
      end
   end

   always @(negedge clk1) begin
      if (rst === 1'b1) begin
         check("model_out", out, exp_out);
         check("model_busy", busy, exp_busy);
         check("model_full", fifo_full, exp_full);
         check("model_overflow", overflow, exp_ovf);
      end
   end

   task automatic wait_idle();
      int quiet = 0;
      data_valid = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk1);
         quiet = busy ? 0 : quiet + 1;
         if (quiet >= 2) return;
      end
      check("wait_idle_timeout", 1, 0);
   endtask

   task automatic frame_check(input string tag, input logic [7:0] b, input logic pe,
                              input logic pt, input logic [10:0] exp_bits, input int nbits);
      @(negedge clk1);
      data = b; data_valid = 1'b1; parity_en = pe; parity_type = pt;
      @(negedge clk1);
      data_valid = 1'b0;
      check({tag, "_pre_start"}, out, 1);
      for (int i = 0; i < nbits; i++) begin
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk1);
            check($sformatf("%s_bit%0d", tag, i), out, exp_bits[i]);
            check($sformatf("%s_busy%0d", tag, i), busy, 1);
         end
      end
      @(negedge clk1);
      check({tag, "_end_busy"}, busy, 0);
      check({tag, "_end_out"}, out, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   logic s [0:99];
   int   bcnt;
   int   rate;

   initial begin
      repeat (3) @(negedge clk1);
      check("reset_out", out, 1);
      check("reset_busy", busy, 0);
      check("reset_full", fifo_full, 0);
      check("reset_overflow", overflow, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk1);

      // Hand-computed frames: 0xA5 plain, 0x03 even and odd parity.
      frame_check("a5", 8'hA5, 1'b0, 1'b0, 11'b01101001010, 10);
      wait_idle();
      frame_check("p_even", 8'h03, 1'b1, 1'b0, 11'b10000000110, 11);
      wait_idle();
      frame_check("p_odd", 8'h03, 1'b1, 1'b1, 11'b11000000110, 11);
      wait_idle();

      // Burst of six: four queue behind the first, the sixth is dropped.
      parity_en = 1'b0;
      bcnt = 0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk1);
         data = 8'h10 + 8'(j); data_valid = 1'b1;
         if (j > 0 && busy) bcnt++;
      end
      @(negedge clk1);
      data_valid = 1'b0;
      if (busy) bcnt++;
      check("burst_full", fifo_full, 1);
      check("burst_overflow", overflow, 1);
      @(negedge clk1);
      if (busy) bcnt++;
      check("burst_overflow_pulse_end", overflow, 0);
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk1);
         if (!busy) break;
         bcnt++;
      end
      check("burst_busy_cycles", bcnt, 200);
      wait_idle();

      // Parity type flipped mid-frame: first frame keeps even, second uses odd.
      @(negedge clk1);
      data = 8'h03; data_valid = 1'b1; parity_en = 1'b1; parity_type = 1'b0;
      @(negedge clk1);
      s[0] = out;
      for (int n = 1; n < 100; n++) begin
         @(negedge clk1);
         if (n == 1)  data_valid = 1'b0;
         if (n == 10) parity_type = 1'b1;
         s[n] = out;
      end
      check("toggle_f1_parity", s[38], 0);
      check("toggle_f1_stop", s[44], 1);
      check("toggle_f2_start", s[45], 0);
      check("toggle_f2_parity", s[82], 1);
      wait_idle();

      // Random traffic with alternating heavy and light load, and an async reset mid-frame.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk1);
         rate        = ((n / 500) % 2 == 1) ? 60 : 2;
         data_valid  = ($urandom_range(0, rate) == 0);
         data        = 8'($urandom);
         parity_en   = 1'($urandom);
         parity_type = 1'($urandom);
         if (n == 1200) begin
            #2 rst = 1'b0;
            #1;
            check("async_rst_out", out, 1);
            check("async_rst_busy", busy, 0);
            check("async_rst_full", fifo_full, 0);
            check("async_rst_overflow", overflow, 0);
            @(negedge clk1);
            data_valid = 1'b0;
            @(negedge clk1);
            rst = 1'b1;
            for (int t = 0; t < 3; t++) begin
               @(negedge clk1);
               check("post_rst_busy", busy, 0);
               check("post_rst_out", out, 1);
            end
         end
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
